// File: rtl/controlador_entradas_param.sv
// Switch/button input controller: synchronises and debounces 2*WIDTH switches plus a
// load button, captures operands A/B on a load press and offers them on a valid/ready port.
`timescale 1ns/1ps
module controlador_entradas_param #(
  parameter int WIDTH       = 8,
  parameter int DEB_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] sw,
  input  logic               btn_load,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   bin_a,
  output logic [WIDTH-1:0]   bin_b,
  output logic               out_valid,
  output logic               dropped,
  output logic [2*WIDTH-1:0] db_sw
);

  localparam int N  = 2*WIDTH + 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic {IDLE, VALID} state_t;

  logic [N-1:0]  raw;
  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  synced;
  logic [CW-1:0] cnt_q  [N];
  logic [N-1:0]  db_q;
  logic          db_load;
  logic          db_load_q;
  logic          load_pulse;
  state_t        state_q, state_d;
  logic          capture;
  logic          drop_req;

  // The button rides in the top bit so it shares the switch synchroniser and debouncer.
  assign raw = {btn_load, sw};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Per-line debounce: a level is accepted after DEB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      db_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (synced[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_q[i]  <= synced[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign db_sw   = db_q[2*WIDTH-1:0];
  assign db_load = db_q[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) db_load_q <= 1'b0;
    else        db_load_q <= db_load;
  end

  assign load_pulse = db_load & ~db_load_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (load_pulse) state_d = VALID;
      VALID: if (out_ready)  state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == VALID);
    capture   = (state_q == IDLE)  && load_pulse;
    drop_req  = (state_q == VALID) && load_pulse;
  end

  // Operands move only on a capture; a press while a capture is pending is flagged, not taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_a   <= '0;
      bin_b   <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= drop_req;
      if (capture) begin
        bin_a <= db_sw[WIDTH-1:0];
        bin_b <= db_sw[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_controlador_entradas_param.sv
// Self-checking bench: window-based behavioural model of the default configuration,
// directed scenarios with literal expectations, then randomized stimulus.
`timescale 1ns/1ps
module tb_controlador_entradas_param;

  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;
  localparam int N = 2*W + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [2*W-1:0] sw;
  logic btn, rdy;
  logic [W-1:0] bin_a, bin_b;
  logic out_valid, dropped;
  logic [2*W-1:0] db_sw;

  logic [7:0] sw2;
  logic btn2, rdy2;
  logic [3:0] bin_a2, bin_b2;
  logic out_valid2, dropped2;
  logic [7:0] db_sw2;

  int total = 0;
  int bad   = 0;
  logic cmp_on = 1'b0;

  always #5 clk = ~clk;

  controlador_entradas_param #(.WIDTH(W), .DEB_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn), .out_ready(rdy),
    .bin_a(bin_a), .bin_b(bin_b), .out_valid(out_valid), .dropped(dropped), .db_sw(db_sw)
  );

  controlador_entradas_param #(.WIDTH(4), .DEB_CYCLES(1), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sw(sw2), .btn_load(btn2), .out_ready(rdy2),
    .bin_a(bin_a2), .bin_b(bin_b2), .out_valid(out_valid2), .dropped(dropped2), .db_sw(db_sw2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: raw samples are delayed S edges; a bit's debounced level flips when the
  // last D delayed samples all disagree with it.
  logic [N-1:0] m_rawq [S];
  logic [N-1:0] m_win  [D];
  logic [N-1:0] m_db;
  logic         m_load_prev;
  logic         m_valid, m_drop;
  logic [W-1:0] m_a, m_b;

  always @(posedge clk) begin
    logic [N-1:0] seen, flip;
    logic pulse;
    if (!rst_n) begin
      for (int j = 0; j < S; j++) m_rawq[j] = '0;
      for (int j = 0; j < D; j++) m_win[j] = '0;
      m_db = '0; m_load_prev = 1'b0; m_valid = 1'b0; m_drop = 1'b0;
      m_a = '0; m_b = '0;
    end else begin
      pulse  = m_db[N-1] & ~m_load_prev;
      m_drop = m_valid & pulse;
      if (m_valid) begin
        if (rdy) m_valid = 1'b0;
      end else if (pulse) begin
        m_a = m_db[W-1:0];
        m_b = m_db[2*W-1:W];
        m_valid = 1'b1;
      end
      m_load_prev = m_db[N-1];
      seen = m_rawq[S-1];
      for (int j = S-1; j > 0; j--) m_rawq[j] = m_rawq[j-1];
      m_rawq[0] = {btn, sw};
      for (int j = D-1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = seen;
      flip = '1;
      for (int j = 0; j < D; j++) flip &= (m_win[j] ^ m_db);
      m_db ^= flip;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model db_sw",     32'(db_sw),     32'(m_db[2*W-1:0]));
      check("model out_valid", 32'(out_valid), 32'(m_valid));
      check("model bin_a",     32'(bin_a),     32'(m_a));
      check("model bin_b",     32'(bin_b),     32'(m_b));
      check("model dropped",   32'(dropped),   32'(m_drop));
    end
  end

  initial begin
    int cnt;
    rst_n = 1'b0; sw = '0; btn = 1'b0; rdy = 1'b0;
    sw2 = '0; btn2 = 1'b0; rdy2 = 1'b0;
    tick(3);
    cmp_on = 1'b1;
    check("reset db_sw", 32'(db_sw), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset bin_a", 32'(bin_a), 32'h0);
    check("reset dropped", 32'(dropped), 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Basic capture with ready high.
    sw = 16'hF0AA; btn = 1'b1; rdy = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (e == 5) check("t1 db_sw edge5", 32'(db_sw), 32'h0);
      if (e == 6) begin
        check("t1 db_sw edge6", 32'(db_sw), 32'hF0AA);
        check("t1 valid edge6", 32'(out_valid), 32'h0);
      end
      if (e == 7) begin
        check("t1 valid edge7", 32'(out_valid), 32'h1);
        check("t1 bin_a", 32'(bin_a), 32'hAA);
        check("t1 bin_b", 32'(bin_b), 32'hF0);
      end
      if (e == 8) check("t1 valid edge8", 32'(out_valid), 32'h0);
    end
    tick(2); btn = 1'b0; sw = '0; tick(12);

    // Glitches: 3 cycles rejected, 4 cycles accepted.
    sw[3] = 1'b1; tick(3); sw[3] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      check("t2 short glitch", 32'(db_sw[3]), 32'h0);
    end
    sw[3] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e == 4) sw[3] = 1'b0;
      if (e == 5)  check("t2 db3 edge5", 32'(db_sw[3]), 32'h0);
      if (e == 6)  check("t2 db3 edge6", 32'(db_sw[3]), 32'h1);
      if (e == 9)  check("t2 db3 edge9", 32'(db_sw[3]), 32'h1);
      if (e == 10) check("t2 db3 edge10", 32'(db_sw[3]), 32'h0);
    end

    // Backpressure and dropped press.
    rdy = 1'b0; sw = 16'h1234; tick(8);
    btn = 1'b1; tick(10);
    check("t3 valid", 32'(out_valid), 32'h1);
    check("t3 bin_a", 32'(bin_a), 32'h34);
    check("t3 bin_b", 32'(bin_b), 32'h12);
    btn = 1'b0; sw = 16'hFFFF; tick(12);
    check("t3 bin_a held", 32'(bin_a), 32'h34);
    check("t3 bin_b held", 32'(bin_b), 32'h12);
    check("t3 db_sw", 32'(db_sw), 32'hFFFF);
    btn = 1'b1; cnt = 0;
    for (int e = 1; e <= 9; e++) begin
      tick(1);
      if (dropped) cnt++;
      if (e == 7) check("t3 dropped edge7", 32'(dropped), 32'h1);
    end
    check("t3 dropped count", 32'(cnt), 32'h1);
    btn = 1'b0; tick(8);
    rdy = 1'b1; tick(1);
    check("t3 valid falls", 32'(out_valid), 32'h0);
    check("t3 bin_a idle", 32'(bin_a), 32'h34);
    tick(2);

    // Held button gives exactly one capture.
    sw = 16'h5A3C; tick(8);
    btn = 1'b1; cnt = 0;
    for (int e = 0; e < 50; e++) begin
      tick(1);
      if (out_valid) cnt++;
    end
    check("t4 one capture", 32'(cnt), 32'h1);
    check("t4 first bin_a", 32'(bin_a), 32'h3C);
    btn = 1'b0; sw = 16'h6699; tick(10);
    btn = 1'b1; cnt = 0;
    for (int e = 0; e < 10; e++) begin
      tick(1);
      if (out_valid) cnt++;
    end
    check("t4 second capture", 32'(cnt), 32'h1);
    check("t4 bin_a", 32'(bin_a), 32'h99);
    check("t4 bin_b", 32'(bin_b), 32'h66);
    btn = 1'b0; tick(10);

    // Reset during a pending capture.
    rdy = 1'b0; sw = 16'h0F0F; tick(8);
    btn = 1'b1; tick(9);
    check("t5 valid before", 32'(out_valid), 32'h1);
    rst_n = 1'b0; tick(1);
    check("t5 valid", 32'(out_valid), 32'h0);
    check("t5 bin_a", 32'(bin_a), 32'h0);
    check("t5 bin_b", 32'(bin_b), 32'h0);
    check("t5 db_sw", 32'(db_sw), 32'h0);
    check("t5 dropped", 32'(dropped), 32'h0);
    rst_n = 1'b1; btn = 1'b0; tick(10);

    // Narrow, fast-debounce instance.
    sw2 = 8'hC3; btn2 = 1'b1; rdy2 = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      if (e == 3) begin
        check("t6 db_sw", 32'(db_sw2), 32'hC3);
        check("t6 valid edge3", 32'(out_valid2), 32'h0);
      end
      if (e == 4) begin
        check("t6 valid edge4", 32'(out_valid2), 32'h1);
        check("t6 bin_a", 32'(bin_a2), 32'h3);
        check("t6 bin_b", 32'(bin_b2), 32'hC);
      end
      if (e == 5) check("t6 valid edge5", 32'(out_valid2), 32'h0);
    end
    btn2 = 1'b0;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      tick(1);
      if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      rdy   = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 599) != 0);
    end
    rst_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
